// File: rtl/mac_window_ctrl.sv
// -----------------------------------------------------------------------------
// mac_window_ctrl
//
// Sequencing controller for the fp16 MAC datapath. Operand pairs arrive on a
// valid/ready handshake and are forwarded to the MAC one tap per cycle. The
// first tap of each window restarts the accumulator. After the last tap the
// controller waits out the MAC latency, captures the sum and offers it on an
// output valid/ready handshake. Data passes through bit-exact.
//
// Parameters
//   TAPS     operand pairs per window (>= 1)
//   MAC_LAT  edges from the MAC sampling mac_en until mac_result reflects it (>= 1)
//   CNT_W    tap counter width (2**CNT_W > TAPS)
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   flush                  synchronous abort of the current window
//   in_valid/in_ready      operand pair handshake, in_pixel/in_kernel payload
//   mac_en/mac_clr         registered MAC strobes (clr only together with en)
//   mac_pixel/mac_kernel   registered operands presented to the MAC
//   mac_result             MAC accumulator output
//   out_valid/out_ready    result handshake, out_data payload
//   busy                   controller not idle
//   tap_cnt                taps accepted in the current window
// -----------------------------------------------------------------------------
module mac_window_ctrl #(
    parameter int TAPS    = 9,
    parameter int MAC_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_pixel,
    input  logic [15:0]      in_kernel,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [15:0]      mac_pixel,
    output logic [15:0]      mac_kernel,
    input  logic [15:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] tap_cnt
);

    localparam int DRAIN_W = $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [CNT_W-1:0]   tap_cnt_q;
    logic [CNT_W-1:0]   tap_cnt_d;
    logic               mac_en_q;
    logic               mac_clr_q;
    logic [15:0]        mac_pixel_q;
    logic [15:0]        mac_kernel_q;
    logic               out_valid_q;
    logic [15:0]        out_data_q;
    logic               accept;

    // Ready depends on state alone, so a result handshake in HOLD never
    // accepts a new pair in the same cycle.
    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign tap_cnt_d = tap_cnt_q + CNT_W'(1);

    // NOTE: every state register is updated with non-blocking assignments so
    // all of them sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            drain_q      <= '0;
            tap_cnt_q    <= '0;
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            mac_pixel_q  <= 16'h0000;
            mac_kernel_q <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_data_q   <= 16'h0000;
        end else begin
            // MAC strobes are single-cycle pulses; only an accept raises them.
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;

            if (flush) begin
                // Abort wins over any same-cycle accept or result handshake.
                state_q     <= IDLE;
                tap_cnt_q   <= '0;
                drain_q     <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (accept) begin
                    mac_en_q     <= 1'b1;
                    mac_pixel_q  <= in_pixel;
                    mac_kernel_q <= in_kernel;
                end

                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            tap_cnt_q <= CNT_W'(1);
                            mac_clr_q <= 1'b1;
                            if (TAPS == 1) begin
                                state_q <= DRAIN;
                                drain_q <= DRAIN_W'(MAC_LAT);
                            end else begin
                                state_q <= ACCUM;
                            end
                        end
                    end

                    ACCUM: begin
                        if (accept) begin
                            tap_cnt_q <= tap_cnt_d;
                            if (tap_cnt_d == CNT_W'(TAPS)) begin
                                state_q <= DRAIN;
                                drain_q <= DRAIN_W'(MAC_LAT);
                            end
                        end
                    end

                    DRAIN: begin
                        // One edge for mac_en to reach the MAC plus MAC_LAT
                        // edges of MAC latency before the sum is final.
                        if (drain_q == '0) begin
                            out_data_q  <= mac_result;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            drain_q <= drain_q - DRAIN_W'(1);
                        end
                    end

                    HOLD: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            tap_cnt_q   <= '0;
                            state_q     <= IDLE;
                        end
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign mac_pixel  = mac_pixel_q;
    assign mac_kernel = mac_kernel_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign tap_cnt    = tap_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mac_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_window_ctrl
//
// Main instance: TAPS=9, MAC_LAT=1, driven by directed sequences and random
// traffic and compared every cycle against a window-level reference model
// (tap count, pending-result countdown, running sum of products).
// Second instance: TAPS=1, MAC_LAT=3, single-pair directed sequence.
// A stand-in MAC (integer multiply folded to 16 bits, accumulate mod 2^16)
// closes the loop; the controller only passes its result through.
// -----------------------------------------------------------------------------
module tb_mac_window_ctrl;

    localparam int TAPS    = 9;
    localparam int MAC_LAT = 1;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_pixel;
    logic [15:0]      in_kernel;
    logic             mac_en;
    logic             mac_clr;
    logic [15:0]      mac_pixel;
    logic [15:0]      mac_kernel;
    logic [15:0]      mac_result;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             busy;
    logic [CNT_W-1:0] tap_cnt;

    logic             in_valid2;
    logic             in_ready2;
    logic [15:0]      in_pixel2;
    logic [15:0]      in_kernel2;
    logic             mac_en2;
    logic             mac_clr2;
    logic [15:0]      mac_pixel2;
    logic [15:0]      mac_kernel2;
    logic [15:0]      mac_result2;
    logic             out_valid2;
    logic             out_ready2;
    logic [15:0]      out_data2;
    logic             busy2;
    logic [CNT_W-1:0] tap_cnt2;
    logic             flush2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_window_ctrl #(.TAPS(TAPS), .MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_kernel(in_kernel),
        .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_pixel(mac_pixel), .mac_kernel(mac_kernel),
        .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .tap_cnt(tap_cnt)
    );

    mac_window_ctrl #(.TAPS(1), .MAC_LAT(3), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_pixel(in_pixel2), .in_kernel(in_kernel2),
        .mac_en(mac_en2), .mac_clr(mac_clr2),
        .mac_pixel(mac_pixel2), .mac_kernel(mac_kernel2),
        .mac_result(mac_result2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .tap_cnt(tap_cnt2)
    );

    // Stand-in MAC product: fold the 32-bit integer product to 16 bits.
    function automatic logic [15:0] prod16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        return p[15:0] ^ p[31:16];
    endfunction

    // Stand-in MAC, latency 1.
    logic [15:0] acc1 = 16'h0000;
    always @(posedge clk)
        if (mac_en)
            acc1 <= mac_clr ? prod16(mac_pixel, mac_kernel)
                            : acc1 + prod16(mac_pixel, mac_kernel);
    assign mac_result = acc1;

    // Stand-in MAC, latency 3.
    logic [15:0] acc2 = 16'h0000;
    logic [15:0] dly2_0 = 16'h0000, dly2_1 = 16'h0000, dly2_2 = 16'h0000;
    logic [15:0] nxt2;
    assign nxt2 = !mac_en2 ? acc2
                : mac_clr2 ? prod16(mac_pixel2, mac_kernel2)
                : acc2 + prod16(mac_pixel2, mac_kernel2);
    always @(posedge clk) begin
        acc2   <= nxt2;
        dly2_0 <= nxt2;
        dly2_1 <= dly2_0;
        dly2_2 <= dly2_1;
    end
    assign mac_result2 = dly2_2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (window level) ----------------
    int          m_taps;   // taps accepted in the current window
    int          m_wait;   // edges left until the result appears, 0 = none
    bit          m_hold;   // result being offered
    logic [15:0] m_sum;
    logic [15:0] m_out;
    bit          m_en;
    bit          m_clr;
    logic [15:0] m_pix;
    logic [15:0] m_ker;

    task automatic model_reset();
        m_taps = 0; m_wait = 0; m_hold = 0;
        m_sum = 16'h0; m_out = 16'h0;
        m_en = 0; m_clr = 0; m_pix = 16'h0; m_ker = 16'h0;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] p, input logic [15:0] k,
                              input bit ordy, input bit fl);
        bit acc;
        acc = v && (m_taps < TAPS) && !fl;
        if (fl) begin
            m_taps = 0; m_wait = 0; m_hold = 0; m_en = 0; m_clr = 0;
            return;
        end
        m_en  = acc;
        m_clr = acc && (m_taps == 0);
        if (acc) begin
            m_pix = p;
            m_ker = k;
            m_sum = (m_taps == 0) ? prod16(p, k) : m_sum + prod16(p, k);
            m_taps++;
            if (m_taps == TAPS) m_wait = MAC_LAT + 1;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_hold = 1;
                m_out  = m_sum;
            end
        end else if (m_hold && ordy) begin
            m_hold = 0;
            m_taps = 0;
        end
    endtask

    task automatic check_outputs();
        check("in_ready",   in_ready,   m_taps < TAPS);
        check("busy",       busy,       m_taps != 0);
        check("tap_cnt",    tap_cnt,    m_taps);
        check("mac_en",     mac_en,     m_en);
        check("mac_clr",    mac_clr,    m_clr);
        check("mac_pixel",  mac_pixel,  m_pix);
        check("mac_kernel", mac_kernel, m_ker);
        check("out_valid",  out_valid,  m_hold);
        check("out_data",   out_data,   m_out);
    endtask

    // One clock: check state left by the previous edge, drive, then advance.
    task automatic step(input bit v, input logic [15:0] p, input logic [15:0] k,
                        input bit ordy, input bit fl);
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_pixel  = p;
        in_kernel = k;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge(v, p, k, ordy, fl);
    endtask

    task automatic rand_pair(output logic [15:0] p, output logic [15:0] k);
        p = 16'($urandom);
        k = 16'($urandom);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, ordy, 1'b0);
    endtask

    initial begin
        logic [15:0] p, k;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pixel = 16'h0;
        in_kernel = 16'h0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_pixel2 = 16'h0; in_kernel2 = 16'h0;
        out_ready2 = 1'b0; flush2 = 1'b0;
        model_reset();

        #7;
        check_outputs();
        check("d2_reset_busy", busy2, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back window of constant operands.
        for (int i = 0; i < TAPS; i++) step(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Same window with a 3-cycle gap between taps 4 and 5.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b0);
        idle(3, 1'b1);
        for (int i = 4; i < TAPS; i++) step(1'b1, 16'h3C00, 16'h4000, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Result back-pressured while new pairs are offered.
        for (int i = 0; i < TAPS; i++) begin
            rand_pair(p, k);
            step(1'b1, p, k, 1'b0, 1'b0);
        end
        for (int i = 0; i < 7; i++) begin
            rand_pair(p, k);
            step(1'b1, p, k, 1'b0, 1'b0);
        end
        rand_pair(p, k);
        step(1'b1, p, k, 1'b1, 1'b0);
        for (int i = 0; i < TAPS + 3; i++) begin
            rand_pair(p, k);
            step(i < TAPS, p, k, 1'b1, 1'b0);
        end

        // Flush after tap 5 with a pair offered in the same cycle.
        for (int i = 0; i < 5; i++) begin
            rand_pair(p, k);
            step(1'b1, p, k, 1'b1, 1'b0);
        end
        step(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < TAPS; i++) begin
            rand_pair(p, k);
            step(1'b1, p, k, 1'b1, 1'b0);
        end
        idle(4, 1'b1);

        // Reset pulsed while draining.
        for (int i = 0; i < TAPS; i++) begin
            rand_pair(p, k);
            step(1'b1, p, k, 1'b1, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        idle(6, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rand_pair(p, k);
            step($urandom_range(9, 0) < 7, p, k, $urandom_range(1, 0) == 1,
                 $urandom_range(39, 0) == 0);
        end
        idle(6, 1'b1);

        // Single-tap window on the TAPS=1, MAC_LAT=3 instance.
        @(negedge clk);
        check("d2_in_ready_idle", in_ready2, 1'b1);
        in_valid2 = 1'b1; in_pixel2 = 16'h3C00; in_kernel2 = 16'h3C00; out_ready2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        check("d2_mac_en",     mac_en2,     1'b1);
        check("d2_mac_clr",    mac_clr2,    1'b1);
        check("d2_mac_pixel",  mac_pixel2,  16'h3C00);
        check("d2_in_ready",   in_ready2,   1'b0);
        check("d2_tap_cnt",    tap_cnt2,    1);
        check("d2_out_valid0", out_valid2,  1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("d2_out_valid%0d", c), out_valid2, c >= 4);
            check($sformatf("d2_mac_en%0d", c), mac_en2, 1'b0);
        end
        check("d2_out_data", out_data2, 16'h0E10);
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready2 = 1'b0;
        check("d2_out_valid_done", out_valid2, 1'b0);
        check("d2_tap_cnt_done",   tap_cnt2,   0);
        check("d2_in_ready_done",  in_ready2,  1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_window_ctrl.md
Name: mac_window_ctrl

Overview:
- Sequencing controller for the 16-bit floating-point MAC datapath.
- Accepts a stream of pixel/kernel operand pairs over a valid/ready handshake and feeds them to the MAC one tap per cycle.
- Restarts the accumulator at the first tap of each window and waits out the MAC latency after the last tap.
- Captures the finished sum and presents it on an output valid/ready handshake; one result per TAPS operand pairs (one convolution window).

Parameters:
- TAPS, 9, operand pairs per window (>=1; 9 = 3x3 kernel).
- MAC_LAT, 1, clock edges from the MAC sampling mac_en until mac_result reflects that tap (>=1).
- CNT_W, 8, width of tap counter (2^CNT_W > TAPS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the current window.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept a pair.
- in_pixel  in  16  fp16 pixel operand.
- in_kernel  in  16  fp16 kernel operand.
- mac_en  out  1  registered: MAC consumes mac_pixel/mac_kernel this cycle.
- mac_clr  out  1  registered, only with mac_en: MAC loads the product instead of adding.
- mac_pixel  out  16  registered pixel to MAC.
- mac_kernel  out  16  registered kernel to MAC.
- mac_result  in  16  MAC accumulator output.
- out_valid  out  1  window result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  16  captured window sum.
- busy  out  1  high in any state except IDLE.
- tap_cnt  out  CNT_W  taps accepted in the current window.

Behaviour:
- Reset (rst=1, async): state IDLE; mac_en, mac_clr, out_valid, tap_cnt, drain counter = 0; mac_pixel, mac_kernel, out_data = 16'h0000.
- Accept = in_valid & in_ready, sampled on the clock edge.
- On each accept: next cycle mac_en=1, mac_pixel/mac_kernel = accepted operands. mac_clr=1 only for the first tap of a window. Otherwise mac_en=0, mac_clr=0, operands hold their last values.
- IDLE:
  - in_ready=1.
  - Accept -> tap_cnt=1, mac_clr issued.
  - If TAPS==1 -> DRAIN; else -> ACCUM.
- ACCUM:
  - in_ready=1; gaps in in_valid are allowed and leave the state unchanged.
  - Each accept increments tap_cnt.
  - The accept making tap_cnt==TAPS -> DRAIN.
- DRAIN:
  - in_ready=0; drain counter loaded with MAC_LAT on entry, decrements each cycle.
  - At zero: out_data <= mac_result, out_valid <= 1, -> HOLD.
  - out_valid rises exactly MAC_LAT+1 cycles after the edge accepting the last tap.
- HOLD:
  - in_ready=0; out_valid=1, out_data stable until out_ready=1.
  - On handshake: out_valid <= 0, tap_cnt <= 0, -> IDLE.
  - The next window can be accepted on the following cycle.
- flush=1 (any state, sync): -> IDLE, tap_cnt=0, out_valid=0, mac_en=0.
  - An in-flight result is discarded.
  - A same-cycle accept is ignored (flush wins).
- Simultaneous out handshake and in_valid in HOLD: no input accepted that cycle; in_ready is a function of state only, not of out_ready.
- tap_cnt never exceeds TAPS; no wrap occurs.
- Reset asserted mid-window returns to the reset values above immediately; no partial result is emitted.
- No arithmetic on data; operands and result pass through bit-exact.

Test Plan:
- Reset then 9 back-to-back pairs (pixel=0x3C00, kernel=0x4000), MAC model sums products, out_ready=1 -> mac_clr only on first mac_en; in_ready low from 10th cycle; out_valid exactly MAC_LAT+1 cycles after 9th accept; out_data = model result.
- Same window with in_valid deasserted 3 cycles between taps 4 and 5 -> tap_cnt holds 4 during gap; result identical to gap-free case.
- out_ready held low 5 cycles after out_valid -> out_data and out_valid stable, in_ready=0 throughout; after handshake, a new window starts and mac_clr re-asserts.
- flush asserted after tap 5 with in_valid=1 -> next cycle IDLE, tap_cnt=0, no mac_en from that beat, no out_valid; the following window produces a correct independent result.
- rst pulsed during DRAIN -> all outputs to reset values asynchronously; no out_valid afterwards.
- TAPS=1, MAC_LAT=3 build: single pair 0x3C00×0x3C00 -> mac_clr & mac_en together; out_valid 4 cycles after accept.
